fir_out_conditioner: RTL and testbench

Output stage directly downstream of `student_fir`. It captures each 32-bit accumulator result `y_out` on the FIR's `valid_strobe_out` pulse, then rounds, scales and saturates it to a 16-bit sample. The sample is buffered in a small first-word-fall-through FIFO and handed to the consumer (DAC/I2S or bus readout) over a valid/ready handshake. Saturation and overflow events are counted and flagged for software.

---
 rtl/fir_pkg.sv | 40 ++++
 rtl/fir_sync_fifo.sv | 55 +++++
 rtl/fir_out_conditioner.sv | 98 +++++++++
 tb/tb_fir_out_conditioner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR output-stage definitions: default widths, saturation limits and
// the round/scale/saturate helper used by output conditioners.
package fir_pkg;

  localparam int FIR_DATA_SIZE = 16;
  localparam int FIR_ACC_WIDTH = 2 * FIR_DATA_SIZE;

  // round_sat works on the widest supported accumulator/sample so that any
  // instance up to these sizes can reuse it.
  localparam int FIR_ACC_MAX  = 64;
  localparam int FIR_DATA_MAX = 32;

  localparam logic [FIR_DATA_SIZE-1:0] SAT_MAX = {1'b0, {(FIR_DATA_SIZE-1){1'b1}}};
  localparam logic [FIR_DATA_SIZE-1:0] SAT_MIN = {1'b1, {(FIR_DATA_SIZE-1){1'b0}}};

  typedef struct packed {
    logic                    sat;
    logic [FIR_DATA_MAX-1:0] value;
  } round_sat_t;

  // Adds half an LSB, arithmetic-shifts and clips to a dsize-bit signed range.
  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic round_sat_t round_sat(input logic signed [FIR_ACC_MAX-1:0] y,
                                           input int shift, input int dsize);
    logic signed [FIR_ACC_MAX:0] one, r, q, hi, lo;
    round_sat_t res;
    one      = '0;
    one[0]   = 1'b1;
    r        = $signed({y[FIR_ACC_MAX-1], y}) + (one <<< (shift - 1));
    q        = r >>> shift;
    hi       = (one <<< (dsize - 1)) - one;
    lo       = -hi - one;
    res.sat  = (q > hi) || (q < lo);
    if (q > hi)      res.value = hi[FIR_DATA_MAX-1:0];
    else if (q < lo) res.value = lo[FIR_DATA_MAX-1:0];
    else             res.value = q[FIR_DATA_MAX-1:0];
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible while non-empty.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int DATA_SIZE  = FIR_DATA_SIZE,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [DATA_SIZE-1:0]          data_i,
  input  logic                          pop_i,
  output logic [DATA_SIZE-1:0]          data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]                            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_DEPTH-1:0][DATA_SIZE-1:0]   mem_q, mem_d;
  logic                                   do_push, do_pop;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    // Pointer MSBs differ only when the writer has lapped the reader.
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    level_o = wptr_q - rptr_q;
    data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);

    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    mem_d   = mem_q;
    if (do_push) mem_d[wptr_q[AW-1:0]] = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fir_out_conditioner.sv
// FIR output stage: capture accumulator, round/scale/saturate to a sample,
// buffer in a FWFT FIFO and report saturation/overflow events.
module fir_out_conditioner
  import fir_pkg::*;
#(
  parameter int DATA_SIZE  = FIR_DATA_SIZE,
  parameter int ACC_WIDTH  = 2 * DATA_SIZE,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_strobe_in,
  input  logic [ACC_WIDTH-1:0]          y_in,
  output logic [DATA_SIZE-1:0]          sample_out,
  output logic                          sample_valid_out,
  input  logic                          sample_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          overflow_out,
  output logic [7:0]                    sat_count_out,
  input  logic                          clr_i
);

  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [ACC_WIDTH-1:0] y1_q, y1_d;
  logic [DATA_SIZE-1:0] s2_data_q, s2_data_d;
  logic                 s2_sat_q, s2_sat_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           sat_cnt_q, sat_cnt_d, cnt_base;
  round_sat_t           rs;
  logic                 unused_rs_hi;

  logic                 fifo_full, fifo_empty, pop, push_drop;
  logic [DATA_SIZE-1:0] fifo_head;

  always_comb begin
    v1_d      = valid_strobe_in;
    y1_d      = valid_strobe_in ? y_in : y1_q;

    rs        = round_sat(FIR_ACC_MAX'(signed'(y1_q)), SHIFT, DATA_SIZE);
    v2_d      = v1_q;
    s2_data_d = v1_q ? rs.value[DATA_SIZE-1:0] : s2_data_q;
    s2_sat_d  = v1_q & rs.sat;

    pop       = sample_ready_in & ~fifo_empty;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    push_drop = v2_q & fifo_full & ~pop;

    // Clear first, then apply this cycle's event so it is never lost.
    ovf_d     = (clr_i ? 1'b0 : ovf_q) | push_drop;
    cnt_base  = clr_i ? 8'd0 : sat_cnt_q;
    sat_cnt_d = (v2_q && s2_sat_q && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
  end

  assign unused_rs_hi = ^rs.value[FIR_DATA_MAX-1:DATA_SIZE];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      ovf_q     <= 1'b0;
      sat_cnt_q <= '0;
      s2_sat_q  <= 1'b0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      ovf_q     <= ovf_d;
      sat_cnt_q <= sat_cnt_d;
      s2_sat_q  <= s2_sat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    y1_q      <= y1_d;
    s2_data_q <= s2_data_d;
  end

  fir_sync_fifo #(
    .DATA_SIZE  (DATA_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (v2_q),
    .data_i  (s2_data_q),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_out)
  );

  assign sample_out       = fifo_head;
  assign sample_valid_out = ~fifo_empty;
  assign overflow_out     = ovf_q;
  assign sat_count_out    = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Scoreboard bench for fir_out_conditioner (SHIFT=15, FIFO_DEPTH=8).
module tb_fir_out_conditioner;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_strobe_in;
  logic [31:0] y_in;
  logic [15:0] sample_out;
  logic        sample_valid_out;
  logic        sample_ready_in;
  logic [3:0]  fifo_level_out;
  logic        overflow_out;
  logic [7:0]  sat_count_out;
  logic        clr_i;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          exp_sat  = 0;
  logic [15:0] exp_q[$];

  fir_out_conditioner #(
    .DATA_SIZE(16), .ACC_WIDTH(32), .SHIFT(15), .FIFO_DEPTH(8)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .valid_strobe_in  (valid_strobe_in),
    .y_in             (y_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .sample_ready_in  (sample_ready_in),
    .fifo_level_out   (fifo_level_out),
    .overflow_out     (overflow_out),
    .sat_count_out    (sat_count_out),
    .clr_i            (clr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic test_reset;
    rst_ni = 1'b0; valid_strobe_in = 1'b0; y_in = '0;
    sample_ready_in = 1'b1; clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_cnt++; if (sample_out !== 16'h0) $display("FAIL reset_sample: got %h want 0000", sample_out); else pass_cnt++;
    chk_cnt++; if (sample_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid_out); else pass_cnt++;
    chk_cnt++; if (fifo_level_out !== 4'd0) $display("FAIL reset_level: got %0d want 0", fifo_level_out); else pass_cnt++;
    chk_cnt++; if (overflow_out !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow_out); else pass_cnt++;
    chk_cnt++; if (sat_count_out !== 8'd0) $display("FAIL reset_sat: got %0d want 0", sat_count_out); else pass_cnt++;
    rst_ni = 1'b1;
  endtask

  task automatic test_round;
    logic [31:0] vy [7]  = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'hFFFF_BFFF,
                             32'hC000_0000, 32'h4000_0000, 32'h8000_0000};
    logic [15:0] ve [7]  = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF,
                             16'h8000, 16'h7FFF, 16'h8000};
    logic        vs [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] e;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      y_in = vy[i]; valid_strobe_in = 1'b1;
      exp_q.push_back(ve[i]);
      if (vs[i]) exp_sat++;
      @(negedge clk_i); valid_strobe_in = 1'b0;
      @(negedge clk_i);
      chk_cnt++; if (sample_valid_out !== 1'b0) $display("FAIL round_early_%0d: valid %b at N+2, want 0", i, sample_valid_out); else pass_cnt++;
      @(negedge clk_i);
      e = exp_q.pop_front();
      chk_cnt++; if (sample_valid_out !== 1'b1 || sample_out !== e)
        $display("FAIL round_%0d: got v=%b %h want v=1 %h", i, sample_valid_out, sample_out, e); else pass_cnt++;
      chk_cnt++; if (sat_count_out !== 8'(exp_sat))
        $display("FAIL sat_count_%0d: got %0d want %0d", i, sat_count_out, exp_sat); else pass_cnt++;
    end
    @(negedge clk_i); clr_i = 1'b1;
    @(negedge clk_i); clr_i = 1'b0; exp_sat = 0;
    chk_cnt++; if (sat_count_out !== 8'd0) $display("FAIL sat_clear: got %0d want 0", sat_count_out); else pass_cnt++;
  endtask

  task automatic test_clear_collide;
    @(negedge clk_i); y_in = 32'h4000_0000; valid_strobe_in = 1'b1;
    @(negedge clk_i); valid_strobe_in = 1'b0;
    @(negedge clk_i); clr_i = 1'b1;
    @(negedge clk_i); clr_i = 1'b0;
    chk_cnt++; if (sat_count_out !== 8'd1) $display("FAIL clear_collide: got %0d want 1", sat_count_out); else pass_cnt++;
    chk_cnt++; if (sample_out !== 16'h7FFF) $display("FAIL clear_collide_data: got %h want 7fff", sample_out); else pass_cnt++;
    @(negedge clk_i); clr_i = 1'b1;
    @(negedge clk_i); clr_i = 1'b0;
  endtask

  task automatic test_overflow;
    int budget = 0;
    logic [15:0] e;
    sample_ready_in = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_i); y_in = 32'(k) << 15; valid_strobe_in = 1'b1;
      if (k <= 8) exp_q.push_back(16'(k));
    end
    @(negedge clk_i); valid_strobe_in = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    chk_cnt++; if (fifo_level_out !== 4'd8) $display("FAIL ovf_level: got %0d want 8", fifo_level_out); else pass_cnt++;
    chk_cnt++; if (overflow_out !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow_out); else pass_cnt++;
    sample_ready_in = 1'b1;
    while (exp_q.size() > 0 && budget < 30) begin
      if (sample_valid_out) begin
        e = exp_q.pop_front();
        chk_cnt++; if (sample_out !== e) $display("FAIL ovf_order: got %h want %h", sample_out, e); else pass_cnt++;
      end
      @(negedge clk_i); budget++;
    end
    chk_cnt++; if (exp_q.size() != 0) begin
      $display("FAIL ovf_drain_timeout: %0d samples left, want 0", exp_q.size()); exp_q.delete();
    end else pass_cnt++;
    chk_cnt++; if (sample_valid_out !== 1'b0 || fifo_level_out !== 4'd0)
      $display("FAIL ovf_ninth_absent: got v=%b lvl=%0d want v=0 lvl=0", sample_valid_out, fifo_level_out); else pass_cnt++;
    clr_i = 1'b1;
    @(negedge clk_i); clr_i = 1'b0;
    chk_cnt++; if (overflow_out !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow_out); else pass_cnt++;
  endtask

  task automatic test_full_pop;
    int budget = 0;
    logic [15:0] e;
    sample_ready_in = 1'b0;
    for (int k = 11; k <= 18; k++) begin
      @(negedge clk_i); y_in = 32'(k) << 15; valid_strobe_in = 1'b1;
      exp_q.push_back(16'(k));
    end
    @(negedge clk_i); valid_strobe_in = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    chk_cnt++; if (fifo_level_out !== 4'd8) $display("FAIL fullpop_fill: got %0d want 8", fifo_level_out); else pass_cnt++;
    y_in = 32'd19 << 15; valid_strobe_in = 1'b1; exp_q.push_back(16'd19);
    @(negedge clk_i); valid_strobe_in = 1'b0;
    @(negedge clk_i); sample_ready_in = 1'b1;
    e = exp_q.pop_front();
    chk_cnt++; if (sample_out !== e) $display("FAIL fullpop_head: got %h want %h", sample_out, e); else pass_cnt++;
    @(negedge clk_i); sample_ready_in = 1'b0;
    chk_cnt++; if (fifo_level_out !== 4'd8) $display("FAIL fullpop_level: got %0d want 8", fifo_level_out); else pass_cnt++;
    chk_cnt++; if (overflow_out !== 1'b0) $display("FAIL fullpop_ovf: got %b want 0", overflow_out); else pass_cnt++;
    sample_ready_in = 1'b1;
    while (exp_q.size() > 0 && budget < 30) begin
      if (sample_valid_out) begin
        e = exp_q.pop_front();
        chk_cnt++; if (sample_out !== e) $display("FAIL fullpop_order: got %h want %h", sample_out, e); else pass_cnt++;
      end
      @(negedge clk_i); budget++;
    end
    chk_cnt++; if (exp_q.size() != 0) begin
      $display("FAIL fullpop_drain_timeout: %0d samples left, want 0", exp_q.size()); exp_q.delete();
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    sample_ready_in = 1'b1;
    @(negedge clk_i); y_in = 32'h4000_0000; valid_strobe_in = 1'b1;
    @(negedge clk_i); y_in = 32'h0001_0000;
    @(negedge clk_i); y_in = 32'h0002_0000; rst_ni = 1'b0;
    @(negedge clk_i); valid_strobe_in = 1'b0; rst_ni = 1'b1;
    chk_cnt++; if (sample_out !== 16'h0 || sample_valid_out !== 1'b0 || fifo_level_out !== 4'd0 ||
                   overflow_out !== 1'b0 || sat_count_out !== 8'd0)
      $display("FAIL midreset_outputs: got s=%h v=%b lvl=%0d ovf=%b sat=%0d want all 0",
               sample_out, sample_valid_out, fifo_level_out, overflow_out, sat_count_out);
    else pass_cnt++;
    repeat (8) begin
      @(negedge clk_i);
      if (sample_valid_out || sat_count_out != 8'd0) seen = 1'b1;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL midreset_leak: got sample/sat after reset, want none"); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round();
    test_clear_collide();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
